// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame levels and the
// default baud parameters used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int   DATA_BITS      = 8;
   localparam logic START_LVL      = 1'b0;
   localparam logic STOP_LVL       = 1'b1;
   localparam int   DEF_BAUD_DIV   = 27;
   localparam int   DEF_OVERSAMPLE = 16;

   function automatic int frame_bits(input int stop_bits);
      return 1 + DATA_BITS + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the logger core (master) and the UART transmitter (slave).
interface uart_tx_if;

   // A byte moves on the rising edge where din_byte_vld and din_ready are both 1;
   // din_byte is only sampled on that edge, and vld while not ready is ignored.
   logic [7:0] din_byte;
   logic       din_byte_vld;
   logic       din_ready;

   modport master (output din_byte, output din_byte_vld, input din_ready);
   modport slave  (input din_byte, input din_byte_vld, output din_ready);

endinterface

// File: rtl/uart_tx_baud.sv
// Oversample tick generator: one-clock tick every BAUD_DIV clocks, phase
// restarted by clr so the first tick lands exactly BAUD_DIV clocks later.
module uart_tx_baud #(
   parameter int BAUD_DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB-first, STOP_BITS stop bits,
// 16x-style oversampled bit timing shared with the receiver.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = DEF_BAUD_DIV,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst,
   uart_tx_if.slave   bus,
   output logic       ser_out,
   output logic       tx_busy,
   output logic       tx_done,
   output tx_state_t  state_dbg
);

   localparam int         FRAME_W   = frame_bits(STOP_BITS);
   localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] SAMP_PEND = 4'(OVERSAMPLE - 2);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_t          state, state_nxt;
   logic [FRAME_W-1:0] shift_q, shift_nxt;
   logic [3:0]         samp_cnt;
   logic [2:0]         bit_cnt;
   logic               last_pend;
   logic               tick, bit_end, accept, ready, done, ser_nxt;

   uart_tx_baud #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .tick (tick)
   );

   assign bit_end = tick && (samp_cnt == SAMP_LAST);
   assign accept  = bus.din_byte_vld && ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = START;
         START:   if (bit_end) state_nxt = DATA;
         DATA:    if (bit_end && (bit_cnt == DATA_LAST)) state_nxt = STOP;
         STOP:    if (done) state_nxt = accept ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // done comes from the pre-registered flag so the frame end costs no extra cycle
   always_comb begin
      done  = (state == STOP) && last_pend && tick && !rst;
      ready = (state == IDLE) || done;
   end

   always_comb begin
      shift_nxt = shift_q;
      if (accept) begin
         shift_nxt = {{STOP_BITS{STOP_LVL}}, bus.din_byte, START_LVL};
      end else if (bit_end && (state != IDLE)) begin
         shift_nxt = {STOP_LVL, shift_q[FRAME_W-1:1]};
      end
   end

   // The line is registered from next-state values, so the start bit begins on the accept edge
   assign ser_nxt = (state_nxt == IDLE) ? STOP_LVL : shift_nxt[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q   <= '1;
         samp_cnt  <= '0;
         bit_cnt   <= '0;
         last_pend <= 1'b0;
         ser_out   <= STOP_LVL;
      end else begin
         shift_q <= shift_nxt;
         ser_out <= ser_nxt;
         if (accept || done) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
         end else if (tick && (state != IDLE)) begin
            if (samp_cnt == SAMP_LAST) begin
               samp_cnt <= '0;
               if ((state == DATA) && (bit_cnt == DATA_LAST)) begin
                  bit_cnt <= '0;
               end else if (state != START) begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end else begin
               samp_cnt <= samp_cnt + 4'd1;
            end
         end
         if (accept || done) begin
            last_pend <= 1'b0;
         end else if ((state == STOP) && tick && (samp_cnt == SAMP_PEND) &&
                      (bit_cnt == STOP_LAST)) begin
            last_pend <= 1'b1;
         end
      end
   end

   assign bus.din_ready = ready;
   assign tx_done       = done;
   assign tx_busy       = ~ready;
   assign state_dbg     = state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (one and two stop bits) checked every clock
// against a per-cycle expected line queue built from the frame format.
module tb_uart_tx;

   localparam int P = 32;

   logic clk;
   logic rst;
   logic v1, v2;
   logic [7:0] b1, b2;
   logic ser1, ser2, busy1, busy2, done1, done2;
   uart_pkg::tx_state_t st1, st2;

   logic exp_q1[$];
   logic exp_q2[$];
   bit   acc1, acc2;
   int   vectors;
   int   miscompares;

   uart_tx_if bus1();
   uart_tx_if bus2();

   uart_tx #(.BAUD_DIV(2), .OVERSAMPLE(16), .STOP_BITS(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus1.slave),
      .ser_out   (ser1),
      .tx_busy   (busy1),
      .tx_done   (done1),
      .state_dbg (st1)
   );

   uart_tx #(.BAUD_DIV(2), .OVERSAMPLE(16), .STOP_BITS(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus2.slave),
      .ser_out   (ser2),
      .tx_busy   (busy2),
      .tx_done   (done2),
      .state_dbg (st2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference frame: start 0, data LSB first, stop 1s, each level held P clocks.
   task automatic push_frame(input int dut, input logic [7:0] b, input int stops);
      for (int i = 0; i < 9 + stops; i++) begin
         logic lvl;
         if (i == 0) lvl = 1'b0;
         else if (i <= 8) lvl = b[i-1];
         else lvl = 1'b1;
         for (int j = 0; j < P; j++) begin
            if (dut == 1) exp_q1.push_back(lvl);
            else exp_q2.push_back(lvl);
         end
      end
   endtask

   // One clock: drive, check this cycle against the model, advance the model.
   task automatic step();
      logic el1, el2;
      bit er1, er2, ed1, ed2;
      bus1.din_byte_vld = v1;
      bus1.din_byte     = b1;
      bus2.din_byte_vld = v2;
      bus2.din_byte     = b2;
      #1;
      er1 = (exp_q1.size() <= 1);
      ed1 = (exp_q1.size() == 1);
      el1 = (exp_q1.size() > 0) ? exp_q1[0] : 1'b1;
      er2 = (exp_q2.size() <= 1);
      ed2 = (exp_q2.size() == 1);
      el2 = (exp_q2.size() > 0) ? exp_q2[0] : 1'b1;
      chk("ser1", ser1, el1);
      chk("ser2", ser2, el2);
      if (rst) begin
         chk("done1_rst", done1, 0);
         chk("done2_rst", done2, 0);
      end else begin
         chk("ready1", bus1.din_ready, er1);
         chk("busy1", busy1, !er1);
         chk("done1", done1, ed1);
         chk("ready2", bus2.din_ready, er2);
         chk("busy2", busy2, !er2);
         chk("done2", done2, ed2);
         if (exp_q1.size() == 0) chk("state1_idle", st1, 0);
      end
      acc1 = v1 && er1 && !rst;
      acc2 = v2 && er2 && !rst;
      if (rst) begin
         exp_q1.delete();
         exp_q2.delete();
      end else begin
         if (exp_q1.size() > 0) void'(exp_q1.pop_front());
         if (exp_q2.size() > 0) void'(exp_q2.pop_front());
         if (acc1) push_frame(1, b1, 1);
         if (acc2) push_frame(2, b2, 2);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Holds vld with byte b until the model accepts it; returns clocks waited.
   task automatic send(input int dut, input logic [7:0] b, output int waited);
      bit got;
      waited = 0;
      got = 1'b0;
      if (dut == 1) begin v1 = 1'b1; b1 = b; end
      else begin v2 = 1'b1; b2 = b; end
      while (!got && waited < 2000) begin
         step();
         waited++;
         got = (dut == 1) ? acc1 : acc2;
      end
      if (dut == 1) begin v1 = 1'b0; b1 = 8'($urandom); end
      else begin v2 = 1'b0; b2 = 8'($urandom); end
   endtask

   initial begin
      int w;
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      v1 = 1'b0; v2 = 1'b0;
      b1 = 8'h00; b2 = 8'h00;
      bus1.din_byte_vld = 1'b0; bus1.din_byte = 8'h00;
      bus2.din_byte_vld = 1'b0; bus2.din_byte = 8'h00;
      @(posedge clk);
      #1;
      run(2);
      rst = 1'b0;

      // idle line after reset
      run(1000);

      // single frame 0x55
      send(1, 8'h55, w);
      chk("acc55_wait", w, 1);
      run(330);

      // back-to-back with vld held: second accept in the tx_done cycle
      send(1, 8'hA3, w);
      send(1, 8'h0F, w);
      chk("b2b_wait", w, 320);
      run(330);

      // vld while busy is ignored until the tx_done cycle
      send(1, 8'h00, w);
      run(99);
      send(1, 8'hFF, w);
      chk("ignore_wait", w, 221);
      run(330);

      // reset mid DATA, then a clean frame
      send(1, 8'h96, w);
      run(149);
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(5);
      send(1, 8'h3C, w);
      chk("after_rst_wait", w, 1);
      run(330);

      // two stop bits
      send(2, 8'h80, w);
      chk("acc80_wait", w, 1);
      run(360);

      // random bytes, gaps and instance choice
      for (int i = 0; i < 20; i++) begin
         run($urandom_range(0, 40));
         send($urandom_range(1, 2), 8'($urandom_range(0, 255)), w);
      end
      run(400);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
